// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter for two requesters sharing one bank of T flip-flops.
// Each command makes the bank behave as a D, T, JK or SR register.
module tff_bank_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic [1:0]   mode_a,
    input  logic [W-1:0] op0_a,
    input  logic [W-1:0] op1_a,
    input  logic         req_b,
    input  logic [1:0]   mode_b,
    input  logic [W-1:0] op0_b,
    input  logic [W-1:0] op1_b,
    output logic         ack_a,
    output logic         ack_b,
    output logic         gnt_id,
    output logic         busy,
    output logic         err,
    output logic [W-1:0] q,
    output logic [W-1:0] qb
);

    // state | meaning
    // IDLE  | waiting for a request; arbitrates when one arrives
    // GRANT | latches the grantee's mode and operands
    // APPLY | toggles the bank at the closing edge; flags illegal SR
    // DONE  | acknowledges the grantee for one cycle
    typedef enum logic [1:0] {IDLE, GRANT, APPLY, DONE} state_t;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    state_t       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic [1:0]   mode_q, mode_d;
    logic [W-1:0] op0_q, op0_d;
    logic [W-1:0] op1_q, op1_d;
    logic [W-1:0] bank_q, bank_d;
    logic         err_q, err_d;
    logic [W-1:0] t;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            mode_q  <= '0;
            op0_q   <= '0;
            op1_q   <= '0;
            bank_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
        end
    end

    // Toggle vector that turns the latched command into a T-flop update.
    always_comb begin
        t = '0;
        case (mode_q)
            MODE_D:  t = op0_q ^ bank_q;
            MODE_T:  t = op0_q;
            MODE_JK: t = (op0_q & ~bank_q) | (op1_q & bank_q);
            MODE_SR: t = (op0_q & ~bank_q & ~op1_q) | (op1_q & bank_q & ~op0_q);
            default: t = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        bank_d  = bank_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d = GRANT;
                    gnt_d   = (req_a && req_b) ? ~gnt_q : req_b;
                end
            end
            GRANT: begin
                mode_d  = gnt_q ? mode_b : mode_a;
                op0_d   = gnt_q ? op0_b  : op0_a;
                op1_d   = gnt_q ? op1_b  : op1_a;
                state_d = APPLY;
            end
            APPLY: begin
                bank_d = bank_q ^ t;
                if ((mode_q == MODE_SR) && (|(op0_q & op1_q))) begin
                    err_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack_a  = (state_q == DONE) && !gnt_q;
    assign ack_b  = (state_q == DONE) && gnt_q;
    assign gnt_id = gnt_q;
    assign busy   = (state_q != IDLE);
    assign err    = err_q;
    assign q      = bank_q;
    assign qb     = ~bank_q;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Scoreboard bench: driver predicts register behaviour per command, monitor
// checks every acknowledge and the bank contents on every cycle.
module tb_tff_bank_arbiter;
    localparam int W = 4;

    logic         clk, rst;
    logic         req_a, req_b;
    logic [1:0]   mode_a, mode_b;
    logic [W-1:0] op0_a, op1_a, op0_b, op1_b;
    logic         ack_a, ack_b, gnt_id, busy, err;
    logic [W-1:0] q, qb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic         who;
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] ref_q;
    logic         ref_err;
    logic         last_gnt;
    logic [W-1:0] cur_q;
    exp_t         mon_e;
    logic [W-1:0] mon_nq;

    tff_bank_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .mode_a(mode_a), .op0_a(op0_a), .op1_a(op1_a),
        .req_b(req_b), .mode_b(mode_b), .op0_b(op0_b), .op1_b(op1_b),
        .ack_a(ack_a), .ack_b(ack_b), .gnt_id(gnt_id), .busy(busy),
        .err(err), .q(q), .qb(qb)
    );

    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register semantics, bit by bit, independent of any toggle formulation.
    function automatic logic [W-1:0] ref_next(input logic [1:0] m, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] cur);
        logic [W-1:0] n;
        n = cur;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'd0: n[i] = a[i];
                2'd1: n[i] = cur[i] ^ a[i];
                2'd2: begin
                    if (a[i] && b[i])  n[i] = ~cur[i];
                    else if (a[i])     n[i] = 1'b1;
                    else if (b[i])     n[i] = 1'b0;
                end
                default: begin
                    if (a[i] && !b[i]) n[i] = 1'b1;
                    else if (b[i] && !a[i]) n[i] = 1'b0;
                end
            endcase
        end
        return n;
    endfunction

    task automatic serve(input logic who);
        logic [1:0]   m;
        logic [W-1:0] a, b;
        m = who ? mode_b : mode_a;
        a = who ? op0_b  : op0_a;
        b = who ? op1_b  : op1_a;
        ref_q = ref_next(m, a, b, ref_q);
        if (m == 2'd3 && (a & b) != '0) ref_err = 1'b1;
        last_gnt = who;
        sb.push_back('{who, ref_q, ref_err});
    endtask

    task automatic set_a(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        mode_a = m; op0_a = a; op1_a = b; req_a = 1'b1;
    endtask

    task automatic set_b(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        mode_b = m; op0_b = a; op1_b = b; req_b = 1'b1;
    endtask

    task automatic issue(input bit ua, input bit ub);
        logic first;
        if (ua && ub) begin
            first = ~last_gnt;
            serve(first);
            serve(~first);
        end else if (ua) begin
            serve(1'b0);
        end else if (ub) begin
            serve(1'b1);
        end
    endtask

    task automatic wait_acks(input int n, input bit hold, input bit spacing);
        int got, budget, prev;
        got = 0; budget = 0; prev = -1;
        while (got < n && budget < 10 * n + 10) begin
            @(negedge clk);
            budget++;
            if (ack_a || ack_b) begin
                got++;
                if (spacing && prev >= 0) chk("ack_spacing", cyc - prev, 4);
                prev = cyc;
                if (got == n) begin
                    req_a = 1'b0; req_b = 1'b0;
                end else if (!hold) begin
                    if (ack_a) req_a = 1'b0;
                    if (ack_b) req_b = 1'b0;
                end
            end
        end
        if (got < n) begin
            chk("ack_timeout", got, n);
            req_a = 1'b0; req_b = 1'b0;
        end
    endtask

    task automatic wait_busy();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!busy && budget < 10);
        if (!busy) chk("busy_timeout", busy, 1);
    endtask

    // Monitor: pops on every ack, checks the bank holds between acks.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sb.delete();
            cur_q = '0;
            chk("rst_no_ack", {ack_a, ack_b}, 0);
        end else begin
            mon_nq = ~q;
            chk("qb_inv", qb, mon_nq);
            chk("both_ack", ack_a & ack_b, 0);
            if (ack_a || ack_b) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {ack_a, ack_b}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_who", ack_b, mon_e.who);
                    chk("gnt_id", gnt_id, mon_e.who);
                    chk("q_result", q, mon_e.q);
                    chk("err", err, mon_e.err);
                    chk("busy_done", busy, 1);
                    cur_q = mon_e.q;
                end
            end else begin
                chk("q_hold", q, cur_q);
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        int pat;
        rst = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        mode_a = '0; mode_b = '0;
        op0_a = '0; op1_a = '0; op0_b = '0; op1_b = '0;
        ref_q = '0; ref_err = 1'b0; last_gnt = 1'b1;

        #10;
        chk("rst_q", q, 0);
        chk("rst_qb", qb, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_ack", {ack_a, ack_b}, 0);
        chk("rst_err", err, 0);
        chk("rst_gnt", gnt_id, 1);
        #5 rst = 1'b1;

        @(negedge clk); set_a(2'd0, 4'b1010, 4'b0000); issue(1, 0); wait_acks(1, 0, 0);
        @(negedge clk); set_a(2'd1, 4'b0011, 4'b0000); issue(1, 0); wait_acks(1, 0, 0);
        @(negedge clk); set_b(2'd2, 4'b0100, 4'b1001); issue(0, 1); wait_acks(1, 0, 0);
        @(negedge clk); set_a(2'd3, 4'b0011, 4'b0110); issue(1, 0); wait_acks(1, 0, 0);

        // Both requesters held across four commands.
        @(negedge clk);
        set_a(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom));
        set_b(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom));
        for (int k = 0; k < 4; k++) serve(~last_gnt);
        wait_acks(4, 1, 1);

        // Operand change while the command is in flight.
        @(negedge clk);
        v = 4'($urandom);
        set_a(2'd0, v, 4'b0000); issue(1, 0);
        wait_busy();
        @(negedge clk);
        op0_a = ~v;
        wait_acks(1, 0, 0);

        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            pat = $urandom_range(1, 3);
            if (pat[0]) set_a(2'($urandom), 4'($urandom), 4'($urandom));
            if (pat[1]) set_b(2'($urandom), 4'($urandom), 4'($urandom));
            issue(pat[0], pat[1]);
            wait_acks(pat == 3 ? 2 : 1, 0, pat == 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of APPLY.
        @(negedge clk);
        set_a(2'd1, 4'b1111, 4'b0000); issue(1, 0);
        wait_busy();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_qb", qb, 4'hF);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_gnt", gnt_id, 1);
        ref_q = '0; ref_err = 1'b0; last_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_b(2'd0, 4'b0110, 4'b0000);
        #1 rst = 1'b1;
        issue(1, 1);
        wait_acks(2, 0, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
